// File: rtl/alarm_trigger.sv
// -----------------------------------------------------------------------------
// alarm_trigger
//
// Consumer side of the alarm-setting path. Compares the running clock time
// against the alarm time from the alarm editor and, on a match, rings a pulsed
// buzzer. While ringing, the user can dismiss or snooze (a bounded number of
// times per alarm event). Ringing stops on its own after RING_SECS seconds.
// Disabling the alarm, or entering alarm-edit mode, aborts any event at once.
//
// Parameters:
//   BEEP_HALF   CLK cycles per buzzer on/off half-period (1..2^20)
//   RING_SECS   seconds of continuous ringing before auto-stop (1..511)
//   SNOOZE_SECS snooze duration in seconds (1..511)
//   MAX_SNOOZE  snoozes allowed per alarm event (1..3)
//
// Ports:
//   CLK         system clock
//   RESETN      asynchronous, active-low reset
//   tick_1s     one-cycle pulse; cur_* already hold the new time in that cycle
//   cur_min     current minute, 0..59
//   cur_sec     current second, 0..59
//   alarm_min   alarm minute, 0..59
//   alarm_sec   alarm second, 0..59
//   alarm_en    alarm enable switch (level)
//   setAlarm    alarm editing mode active (level)
//   KEY         one-hot keys: 4'b0001 dismiss, 4'b0010 snooze, others ignored
//   ringing     high while the alarm is ringing
//   buzzer      pulsed buzzer drive
//   snoozing    high while snoozing
//   snooze_cnt  snoozes used in the current alarm event
// -----------------------------------------------------------------------------
module alarm_trigger #(
    parameter int unsigned BEEP_HALF   = 500000,
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       tick_1s,
    input  logic [6:0] cur_min,
    input  logic [6:0] cur_sec,
    input  logic [6:0] alarm_min,
    input  logic [6:0] alarm_sec,
    input  logic       alarm_en,
    input  logic       setAlarm,
    input  logic [3:0] KEY,
    output logic       ringing,
    output logic       buzzer,
    output logic       snoozing,
    output logic [1:0] snooze_cnt
);

    // -------------------------------------------------------------------------
    // State encoding and derived constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;
    localparam logic [1:0] ST_SNOOZE  = 2'd3;

    localparam logic [3:0] KEY_DISMISS = 4'b0001;
    localparam logic [3:0] KEY_SNOOZE  = 4'b0010;

    // Terminal values of the counters; comparing against N-1 lets the tick
    // that completes the N-th second cause the transition directly.
    localparam logic [8:0]  RING_LAST    = 9'(RING_SECS - 1);
    localparam logic [8:0]  SNOOZE_LAST  = 9'(SNOOZE_SECS - 1);
    localparam logic [19:0] BEEP_LAST    = 20'(BEEP_HALF - 1);
    localparam logic [1:0]  SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]  state_q,      state_d;
    logic [8:0]  sec_cnt_q,    sec_cnt_d;
    logic [19:0] beep_cnt_q,   beep_cnt_d;
    logic        buzzer_q,     buzzer_d;
    logic        ringing_q,    ringing_d;
    logic        snoozing_q,   snoozing_d;
    logic [1:0]  snooze_cnt_q, snooze_cnt_d;
    logic [3:0]  key_prev_q,   key_prev_d;

    // -------------------------------------------------------------------------
    // Input qualification
    // -------------------------------------------------------------------------
    logic enabled;
    logic key_idle;
    logic dismiss_press;
    logic snooze_press;
    logic any_press;
    logic time_match;

    assign enabled       = alarm_en & ~setAlarm;
    // A press is a valid code appearing after an all-released cycle, so a
    // held key acts exactly once.
    assign key_idle      = (key_prev_q == 4'b0000);
    assign dismiss_press = key_idle && (KEY == KEY_DISMISS);
    assign snooze_press  = key_idle && (KEY == KEY_SNOOZE);
    assign any_press     = dismiss_press | snooze_press;
    assign time_match    = (cur_min == alarm_min) && (cur_sec == alarm_sec);

    assign key_prev_d = KEY;

    // -------------------------------------------------------------------------
    // Main state machine: state, second counter, snooze count
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default here so no path through the
        // case statement leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;

        if (!enabled) begin
            // Disable aborts everything; the event is not resumed later.
            state_d      = ST_IDLE;
            sec_cnt_d    = '0;
            snooze_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end

                ST_ARMED: begin
                    if (tick_1s && time_match) begin
                        state_d   = ST_RINGING;
                        sec_cnt_d = '0;
                    end
                end

                ST_RINGING: begin
                    if (dismiss_press) begin
                        state_d      = ST_ARMED;
                        snooze_cnt_d = '0;
                    end else if (snooze_press) begin
                        if (snooze_cnt_q < SNOOZE_LIMIT) begin
                            state_d      = ST_SNOOZE;
                            snooze_cnt_d = snooze_cnt_q + 2'd1;
                            sec_cnt_d    = '0;
                        end else begin
                            // Snooze budget exhausted: behaves as dismiss.
                            state_d      = ST_ARMED;
                            snooze_cnt_d = '0;
                        end
                    end else if (tick_1s) begin
                        if (sec_cnt_q == RING_LAST) begin
                            state_d      = ST_ARMED;
                            snooze_cnt_d = '0;
                            sec_cnt_d    = '0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 9'd1;
                        end
                    end
                end

                ST_SNOOZE: begin
                    if (dismiss_press) begin
                        state_d      = ST_ARMED;
                        snooze_cnt_d = '0;
                        sec_cnt_d    = '0;
                    end else if (snooze_press) begin
                        // Ignored, but it still consumes a coincident tick.
                        state_d = ST_SNOOZE;
                    end else if (tick_1s) begin
                        if (sec_cnt_q == SNOOZE_LAST) begin
                            state_d   = ST_RINGING;
                            sec_cnt_d = '0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 9'd1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Buzzer pattern: starts high on every entry into RINGING, then toggles
    // each BEEP_HALF cycles. Outside RINGING it is silent and the beep counter
    // rests at zero, so the next entry always starts a fresh on-phase.
    // -------------------------------------------------------------------------
    always_comb begin
        beep_cnt_d = '0;
        buzzer_d   = 1'b0;

        if (state_d == ST_RINGING) begin
            if (state_q != ST_RINGING) begin
                buzzer_d   = 1'b1;
                beep_cnt_d = '0;
            end else if (beep_cnt_q == BEEP_LAST) begin
                buzzer_d   = ~buzzer_q;
                beep_cnt_d = '0;
            end else begin
                buzzer_d   = buzzer_q;
                beep_cnt_d = beep_cnt_q + 20'd1;
            end
        end
    end

    // Status outputs are registered copies of the next state so they line up
    // with the state register and never glitch.
    always_comb begin
        ringing_d  = (state_d == ST_RINGING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            sec_cnt_q    <= '0;
            beep_cnt_q   <= '0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
            snooze_cnt_q <= '0;
            key_prev_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values computed from the previous cycle, independent of order.
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            beep_cnt_q   <= beep_cnt_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
            snooze_cnt_q <= snooze_cnt_d;
            key_prev_q   <= key_prev_d;
        end
    end

    assign ringing    = ringing_q;
    assign buzzer     = buzzer_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// -----------------------------------------------------------------------------
// tb_alarm_trigger
//
// Scoreboard bench for alarm_trigger. A stimulus process applies inputs on the
// falling edge, advances a behavioural reference model (time kept as seconds
// of the hour, elapsed seconds and ring age kept as plain integers) and pushes
// the expected registered outputs into a queue. A monitor pops one entry after
// each rising edge and compares. Directed scenarios are followed by a long
// randomized run.
// -----------------------------------------------------------------------------
module tb_alarm_trigger;

    localparam int BEEP_HALF   = 4;
    localparam int RING_SECS   = 5;
    localparam int SNOOZE_SECS = 3;
    localparam int MAX_SNOOZE  = 3;

    logic       CLK;
    logic       RESETN;
    logic       tick_1s;
    logic [6:0] cur_min, cur_sec;
    logic [6:0] alarm_min, alarm_sec;
    logic       alarm_en;
    logic       setAlarm;
    logic [3:0] KEY;
    logic       ringing, buzzer, snoozing;
    logic [1:0] snooze_cnt;

    alarm_trigger #(
        .BEEP_HALF  (BEEP_HALF),
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .tick_1s   (tick_1s),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .alarm_min (alarm_min),
        .alarm_sec (alarm_sec),
        .alarm_en  (alarm_en),
        .setAlarm  (setAlarm),
        .KEY       (KEY),
        .ringing   (ringing),
        .buzzer    (buzzer),
        .snoozing  (snoozing),
        .snooze_cnt(snooze_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef enum {M_OFF, M_WAIT, M_RING, M_NAP} mode_t;

    typedef struct {
        int ring;
        int buzz;
        int nap;
        int used;
    } exp_t;

    exp_t  exp_q[$];
    mode_t m_mode;
    int    m_used;     // snoozes used this event
    int    m_elapsed;  // whole seconds spent in the current ring/snooze
    int    m_age;      // cycles since entering the ring phase
    int    m_prev_key;

    int t_now;         // current time, seconds of the hour
    int t_alarm;       // alarm time, seconds of the hour

    task automatic model_reset();
        m_mode     = M_OFF;
        m_used     = 0;
        m_elapsed  = 0;
        m_age      = 0;
        m_prev_key = 0;
    endtask

    task automatic enter_ring();
        m_mode    = M_RING;
        m_elapsed = 0;
        m_age     = 0;
    endtask

    task automatic back_to_wait();
        m_mode = M_WAIT;
        m_used = 0;
    endtask

    // One clock edge worth of behaviour, from the inputs currently applied.
    task automatic model_step();
        bit   en, dis, snz, match;
        exp_t e;
        en    = alarm_en && !setAlarm;
        dis   = (m_prev_key == 0) && (KEY == 4'b0001);
        snz   = (m_prev_key == 0) && (KEY == 4'b0010);
        match = tick_1s && (t_now == t_alarm);

        if (!en) begin
            m_mode = M_OFF;
            m_used = 0;
        end else begin
            case (m_mode)
                M_OFF:  m_mode = M_WAIT;
                M_WAIT: if (match) enter_ring();
                M_RING: begin
                    if (dis) back_to_wait();
                    else if (snz) begin
                        if (m_used < MAX_SNOOZE) begin
                            m_mode    = M_NAP;
                            m_used    = m_used + 1;
                            m_elapsed = 0;
                        end else back_to_wait();
                    end else begin
                        if (tick_1s) m_elapsed++;
                        if (m_elapsed == RING_SECS) back_to_wait();
                        else m_age++;
                    end
                end
                M_NAP: begin
                    if (dis) back_to_wait();
                    else if (!snz && tick_1s) begin
                        m_elapsed++;
                        if (m_elapsed == SNOOZE_SECS) enter_ring();
                    end
                end
            endcase
        end
        m_prev_key = int'(KEY);

        e.ring = (m_mode == M_RING) ? 1 : 0;
        e.buzz = (m_mode == M_RING && ((m_age / BEEP_HALF) % 2) == 0) ? 1 : 0;
        e.nap  = (m_mode == M_NAP) ? 1 : 0;
        e.used = m_used;
        exp_q.push_back(e);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers: called on a falling edge, return on the next one.
    // -------------------------------------------------------------------------
    task automatic apply_time();
        cur_min   = 7'(t_now / 60);
        cur_sec   = 7'(t_now % 60);
        alarm_min = 7'(t_alarm / 60);
        alarm_sec = 7'(t_alarm % 60);
    endtask

    task automatic drive(input bit tk, input logic [3:0] k);
        if (tk) t_now = (t_now + 1) % 3600;
        apply_time();
        tick_1s = tk;
        KEY     = k;
        model_step();
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'b0000);
    endtask

    task automatic hit_alarm();
        t_now = (t_alarm + 3599) % 3600;
        drive(1'b1, 4'b0000);
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (RESETN && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ringing",    int'(ringing),    e.ring);
                check("buzzer",     int'(buzzer),     e.buzz);
                check("snoozing",   int'(snoozing),   e.nap);
                check("snooze_cnt", int'(snooze_cnt), e.used);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int r;
        RESETN   = 1'b0;
        tick_1s  = 1'b0;
        KEY      = 4'b0000;
        alarm_en = 1'b1;
        setAlarm = 1'b0;
        t_alarm  = 7 * 60 + 30;
        t_now    = t_alarm - 2;
        apply_time();
        model_reset();

        repeat (3) @(negedge CLK);
        check("reset ringing",    int'(ringing),    0);
        check("reset buzzer",     int'(buzzer),     0);
        check("reset snoozing",   int'(snoozing),   0);
        check("reset snooze_cnt", int'(snooze_cnt), 0);
        RESETN = 1'b1;

        // Basic match and buzzer pattern.
        idle(3);
        drive(1'b1, 4'b0000);
        idle(2);
        drive(1'b1, 4'b0000);
        idle(10);

        // Dismiss held for 10 cycles, then ring again on the next match.
        repeat (10) drive(1'b0, 4'b0001);
        idle(2);
        hit_alarm();
        idle(3);

        // Snooze loop up to the limit, then a further snooze dismisses.
        for (int s = 0; s < MAX_SNOOZE; s++) begin
            drive(1'b0, 4'b0010);
            idle(1);
            for (int k = 0; k < SNOOZE_SECS; k++) begin
                drive(1'b1, 4'b0000);
                idle(1);
            end
            idle(2);
        end
        drive(1'b0, 4'b0010);
        idle(3);

        // Auto-timeout with no keys.
        hit_alarm();
        for (int k = 0; k < RING_SECS + 1; k++) begin
            idle(2);
            drive(1'b1, 4'b0000);
        end
        idle(2);

        // Disable and edit.
        hit_alarm();
        idle(3);
        setAlarm = 1'b1;
        idle(2);
        hit_alarm();
        idle(2);
        setAlarm = 1'b0;
        idle(2);
        hit_alarm();
        idle(2);
        drive(1'b0, 4'b0001);
        idle(2);

        // Snooze press coinciding with the last snooze tick.
        hit_alarm();
        drive(1'b0, 4'b0010);
        idle(1);
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0010);
        idle(1);
        drive(1'b1, 4'b0000);
        idle(2);

        // Asynchronous reset in the middle of a snooze.
        drive(1'b0, 4'b0010);
        idle(2);
        #2;
        check("pre-reset snoozing", int'(snoozing), 1);
        RESETN = 1'b0;
        #1;
        check("async ringing",    int'(ringing),    0);
        check("async buzzer",     int'(buzzer),     0);
        check("async snoozing",   int'(snoozing),   0);
        check("async snooze_cnt", int'(snooze_cnt), 0);
        KEY = 4'b0000;
        tick_1s = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        idle(2);

        // Randomized run.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] k;
            bit tk;
            r = $urandom_range(0, 999);
            if (r < 8)       alarm_en = ~alarm_en;
            else if (r < 16) setAlarm = ~setAlarm;
            else if (r < 20) t_alarm = $urandom_range(0, 3599);
            if ($urandom_range(0, 99) < 3) t_now = (t_alarm + 3599) % 3600;
            tk = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 99);
            if (r < 88)      k = 4'b0000;
            else if (r < 92) k = 4'b0001;
            else if (r < 97) k = 4'b0010;
            else             k = 4'($urandom_range(0, 15));
            drive(tk, k);
        end

        idle(2);
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
